// File: rtl/tim_pkg.sv
// Shared types and register-map constants for the frame timing sequencer.
package tim_pkg;
  localparam int HA_W  = 3;
  localparam int D_W   = 8;
  localparam int VA_W  = 2;
  localparam int GAP_W = 16;

  localparam logic [HA_W-1:0] A_GAP_LO = 3'd4;
  localparam logic [HA_W-1:0] A_GAP_HI = 3'd5;
  localparam logic [HA_W-1:0] A_COUNT  = 3'd6;
  localparam logic [HA_W-1:0] A_TMO    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TRIG,
    S_WAIT_ON,
    S_WAIT_OFF,
    S_GAP
  } state_t;
endpackage

// File: rtl/tim_dcnt.sv
// Loadable down-counter that holds at zero; load wins over enable.
module tim_dcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_val;
    else if (i_en && r_cnt != '0)
      r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/tim_seq.sv
// Frame sequencer: replays shadow regs into the vertical FSM, triggers,
// tracks the active frame, then idles for a gap before the next frame.
module tim_seq
  import tim_pkg::*;
#(
  parameter int TO_SHIFT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [HA_W-1:0] host_a,
  input  logic [D_W-1:0]  host_d,
  input  logic            host_we,
  input  logic            start,
  input  logic            abort,
  input  logic            vact,
  output logic [VA_W-1:0] vfsm_a,
  output logic [D_W-1:0]  vfsm_d,
  output logic            vfsm_we,
  output logic            vfsm_trigger,
  output logic            busy,
  output logic            frame_done,
  output logic            err,
  output logic [D_W-1:0]  frames_left
);
  localparam int TO_W = GAP_W + TO_SHIFT;

  state_t r_state, w_nxt;
  logic [D_W-1:0] r_shadow [4];
  logic [D_W-1:0] r_gap_lo, r_gap_hi, r_count, r_tmo;
  logic [D_W-1:0] r_frames_left;
  logic [1:0]     r_idx;
  logic           r_err, r_fdone;

  logic [GAP_W-1:0] w_gap, w_gap_val;
  logic [TO_W-1:0]  w_to_val;
  logic w_gap_zero, w_to_zero, w_to_hit;
  logic w_start, w_fend, w_tmo, w_gap_ld, w_to_ld;
  logic w_in_wait;

  assign w_gap     = {r_gap_hi, r_gap_lo};
  assign w_gap_val = w_gap - GAP_W'(1);
  assign w_to_val  = (TO_W'(r_tmo) << TO_SHIFT) - TO_W'(1);
  assign w_in_wait = (r_state == S_WAIT_ON) || (r_state == S_WAIT_OFF);
  assign w_to_hit  = (r_tmo != '0) && w_to_zero;

  // Shadow regs always writable; sequence params frozen while busy
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_shadow[i] <= '0;
      r_gap_lo <= '0;
      r_gap_hi <= '0;
      r_count  <= '0;
      r_tmo    <= '0;
    end else if (host_we) begin
      if (!host_a[2])
        r_shadow[host_a[1:0]] <= host_d;
      else if (r_state == S_IDLE) begin
        unique case (host_a)
          A_GAP_LO: r_gap_lo <= host_d;
          A_GAP_HI: r_gap_hi <= host_d;
          A_COUNT:  r_count  <= host_d;
          default:  r_tmo    <= host_d;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_frames_left <= '0;
      r_err         <= 1'b0;
      r_fdone       <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_fdone <= w_fend;
      r_idx   <= (r_state == S_LOAD && w_nxt == S_LOAD) ?
                 r_idx + 2'd1 : 2'd0;
      if (w_start) begin
        r_frames_left <= r_count;
        r_err         <= 1'b0;
      end else if (w_fend && r_count != '0)
        r_frames_left <= r_frames_left - 8'd1;
      if (w_tmo)
        r_err <= 1'b1;
    end
  end

  always_comb begin
    w_nxt    = r_state;
    w_start  = 1'b0;
    w_fend   = 1'b0;
    w_tmo    = 1'b0;
    w_gap_ld = 1'b0;
    w_to_ld  = 1'b0;
    if (abort && r_state != S_IDLE)
      w_nxt = S_IDLE;
    else begin
      unique case (r_state)
        S_IDLE:
          if (start && !abort) begin
            w_start = 1'b1;
            w_nxt   = S_LOAD;
          end
        S_LOAD:
          if (r_idx == 2'd3) w_nxt = S_TRIG;
        S_TRIG: begin
          w_nxt   = S_WAIT_ON;
          w_to_ld = 1'b1;
        end
        S_WAIT_ON:
          if (vact) begin
            w_nxt   = S_WAIT_OFF;
            w_to_ld = 1'b1;
          end else if (w_to_hit) begin
            w_tmo = 1'b1;
            w_nxt = S_IDLE;
          end
        S_WAIT_OFF:
          // A frame ending on the expiry cycle counts as a good frame
          if (!vact) begin
            w_fend = 1'b1;
            if (r_count != '0 && r_frames_left == 8'd1)
              w_nxt = S_IDLE;
            else if (w_gap == '0)
              w_nxt = S_LOAD;
            else begin
              w_nxt    = S_GAP;
              w_gap_ld = 1'b1;
            end
          end else if (w_to_hit) begin
            w_tmo = 1'b1;
            w_nxt = S_IDLE;
          end
        S_GAP:
          if (w_gap_zero) w_nxt = S_LOAD;
        default:
          w_nxt = S_IDLE;
      endcase
    end
  end

  tim_dcnt #(.W(GAP_W)) u_gap (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_gap_ld),
    .i_val  (w_gap_val),
    .i_en   (r_state == S_GAP),
    .o_zero (w_gap_zero)
  );

  tim_dcnt #(.W(TO_W)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_to_ld),
    .i_val  (w_to_val),
    .i_en   (w_in_wait),
    .o_zero (w_to_zero)
  );

  assign busy         = (r_state != S_IDLE);
  assign vfsm_we      = (r_state == S_LOAD) && !abort;
  assign vfsm_trigger = (r_state == S_TRIG) && !abort;
  assign vfsm_a       = (r_state == S_LOAD) ? r_idx : '0;
  assign vfsm_d       = (r_state == S_LOAD) ? r_shadow[r_idx] : '0;
  assign frame_done   = r_fdone;
  assign err          = r_err;
  assign frames_left  = r_frames_left;
endmodule

// File: tb/tb_tim_seq.sv
// Scoreboard bench for tim_seq: expected event stream vs. observed outputs.
module tb_tim_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] host_a;
  logic [7:0] host_d;
  logic       host_we, start, abort;
  logic       vact, vact_en, r_vm, r_vman;
  logic [1:0] vfsm_a;
  logic [7:0] vfsm_d, frames_left;
  logic       vfsm_we, vfsm_trigger, busy, frame_done, err;

  assign vact = vact_en ? r_vm : r_vman;

  tim_seq dut (
    .clk(clk), .rst(rst), .host_a(host_a), .host_d(host_d),
    .host_we(host_we), .start(start), .abort(abort), .vact(vact),
    .vfsm_a(vfsm_a), .vfsm_d(vfsm_d), .vfsm_we(vfsm_we),
    .vfsm_trigger(vfsm_trigger), .busy(busy), .frame_done(frame_done),
    .err(err), .frames_left(frames_left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] k;
    logic [1:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t q[$];
  int  n_chk = 0, n_fail = 0;
  int  exp_gap = 0, exp_to_lat = 0;
  logic [7:0] m_sh [4];
  int  m_gap, m_cnt, m_to;
  bit  m_busy;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic ev_chk(input ev_t got);
    ev_t e;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event got k=%0d a=%0d d=%0d required none",
               got.k, got.a, got.d);
    end else begin
      e = q.pop_front();
      if (e !== got) begin
        n_fail++;
        $display("FAIL event got k=%0d a=%0d d=%0d required k=%0d a=%0d d=%0d",
                 got.k, got.a, got.d, e.k, e.a, e.d);
      end
    end
  endtask

  // Monitor: kinds 0=write 1=trigger 2=frame_done 3=error
  initial begin
    int cyc = 0, last_fd = 0, last_wr = -10, trig_cyc = 0;
    bit gap_pend = 0, prev_err = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (start || abort || !rst) gap_pend = 0;
      if (err && !prev_err) begin
        ev_chk({2'd3, 2'd0, 8'd0});
        chk("to_latency", cyc - trig_cyc, exp_to_lat);
        chk("to_idle", busy, 0);
      end
      prev_err = err;
      if (frame_done) begin
        ev_chk({2'd2, 2'd0, frames_left});
        last_fd  = cyc;
        gap_pend = 1;
      end
      if (vfsm_we) begin
        ev_chk({2'd0, vfsm_a, vfsm_d});
        if (vfsm_a == 2'd0 && gap_pend)
          chk("gap_len", cyc - last_fd, exp_gap);
        if (vfsm_a != 2'd0)
          chk("wr_consec", cyc, last_wr + 1);
        gap_pend = 0;
        last_wr  = cyc;
      end
      if (vfsm_trigger) begin
        ev_chk({2'd1, 2'd0, 8'd0});
        chk("trig_after_wr", cyc, last_wr + 1);
        trig_cyc = cyc;
      end
    end
  end

  // Vertical FSM stand-in: random delay, random active length
  initial begin
    r_vm = 1'b0;
    forever begin
      @(negedge clk);
      if (vact_en && vfsm_trigger) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 r_vm = 1'b1;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 r_vm = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk);
    #1 host_a = a; host_d = d; host_we = 1'b1;
    if (a < 3'd4) m_sh[a[1:0]] = d;
    else if (!m_busy) begin
      case (a)
        3'd4: m_gap = (m_gap & 'hff00) | int'(d);
        3'd5: m_gap = (m_gap & 'h00ff) | (int'(d) << 8);
        3'd6: m_cnt = d;
        default: m_to = d;
      endcase
    end
    @(posedge clk);
    #1 host_we = 1'b0;
  endtask

  task automatic prog(input int cnt, input int gap, input int to);
    for (int a = 0; a < 4; a++) wr(3'(a), 8'($urandom_range(1, 255)));
    wr(3'd4, 8'(gap));
    wr(3'd5, 8'(gap >> 8));
    wr(3'd6, 8'(cnt));
    wr(3'd7, 8'(to));
    exp_gap    = m_gap;
    exp_to_lat = 1 + (m_to << 8);
  endtask

  task automatic push_wr_trig();
    for (int a = 0; a < 4; a++) q.push_back({2'd0, 2'(a), m_sh[a]});
    q.push_back({2'd1, 2'd0, 8'd0});
  endtask

  task automatic push_frame(input int fl);
    push_wr_trig();
    q.push_back({2'd2, 2'd0, 8'(fl)});
  endtask

  task automatic go();
    @(posedge clk);
    #1 start = 1'b1; m_busy = 1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("err_clear_on_start", err, 0);
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d_pending required=0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_trig();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vfsm_trigger && n < 100);
    chk("trig_seen", vfsm_trigger, 1);
  endtask

  task automatic run_std(input int cnt, input int gap);
    prog(cnt, gap, 0);
    for (int f = 0; f < cnt; f++) push_frame(cnt - 1 - f);
    go();
    drain(120 * cnt + 20);
    m_busy = 0;
    @(negedge clk);
    chk("busy_end", busy, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_sh[i] = 8'd0;
    m_gap = 0; m_cnt = 0; m_to = 0; m_busy = 0;
  endtask

  initial begin
    int n;
    rst = 1'b0; host_a = '0; host_d = '0; host_we = 1'b0;
    start = 1'b0; abort = 1'b0; vact_en = 1'b1; r_vman = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_outs", {vfsm_we, vfsm_trigger, busy, frame_done, err,
                       vfsm_a, vfsm_d, frames_left}, 0);

    // Single frame with the classic register pattern
    wr(3'd0, 8'd11); wr(3'd1, 8'd22); wr(3'd2, 8'd33); wr(3'd3, 8'd44);
    wr(3'd4, 8'd0); wr(3'd5, 8'd0); wr(3'd6, 8'd1); wr(3'd7, 8'd0);
    exp_gap = m_gap;
    push_frame(0);
    go();
    drain(100);
    m_busy = 0;
    @(negedge clk);
    chk("busy_end_single", busy, 0);

    run_std(3, 5);

    // Timeout with vact held low
    vact_en = 1'b0; r_vman = 1'b0;
    prog(1, 0, 1);
    push_wr_trig();
    q.push_back({2'd3, 2'd0, 8'd0});
    go();
    drain(400);
    m_busy = 0;
    @(negedge clk);
    chk("err_sticky", err, 1);
    wr(3'd7, 8'd0);
    vact_en = 1'b1;

    // Abort in the middle of the register replay
    prog(2, 1, 0);
    q.push_back({2'd0, 2'd0, m_sh[0]});
    q.push_back({2'd0, 2'd1, m_sh[1]});
    go();
    n = 0;
    while (!(vfsm_we && vfsm_a == 2'd1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("saw_wr1", vfsm_we && vfsm_a == 2'd1, 1);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    m_busy = 0;
    @(negedge clk);
    chk("abort_load_idle", busy, 0);
    drain(4);

    // Abort lands on the same cycle vact falls: no frame_done
    vact_en = 1'b0;
    prog(1, 0, 0);
    push_wr_trig();
    go();
    wait_trig();
    @(posedge clk);
    #1 r_vman = 1'b1;
    @(posedge clk);
    #1 r_vman = 1'b0; abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    m_busy = 0;
    repeat (3) @(negedge clk);
    chk("abort_vact_idle", busy, 0);
    drain(4);
    vact_en = 1'b1;

    // Continuous mode, stopped by abort during a gap
    prog(0, 4, 0);
    for (int f = 0; f < 3; f++) push_frame(0);
    go();
    drain(300);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    m_busy = 0;
    @(negedge clk);
    chk("cont_abort_idle", busy, 0);
    chk("cont_frames_left", frames_left, 0);

    // Host writes while busy: gap frozen, shadow updated for next LOAD
    prog(2, 3, 0);
    push_frame(1);
    go();
    wait_trig();
    wr(3'd4, 8'd9);
    wr(3'd0, 8'($urandom_range(1, 255)));
    push_frame(0);
    drain(200);
    m_busy = 0;
    @(negedge clk);
    chk("busy_end_wr", busy, 0);

    // Reset while waiting for the end of the active frame
    vact_en = 1'b0;
    prog(1, 0, 0);
    push_wr_trig();
    go();
    wait_trig();
    @(posedge clk);
    #1 r_vman = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1; r_vman = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_mid_outs", {vfsm_we, vfsm_trigger, busy, frame_done, err,
                         vfsm_a, vfsm_d, frames_left}, 0);
    drain(4);
    vact_en = 1'b1;

    for (int i = 0; i < 6; i++)
      run_std($urandom_range(1, 3), $urandom_range(0, 6));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tim_seq.md
TIM_SEQ -- requirements
Module: tim_seq

Interface
REQ-001 SHALL have parameter TO_SHIFT, default 8: left-shift applied to timeout register to form timeout cycle count.
REQ-002 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-004 SHALL have port host_a  in  3  host register address.
REQ-005 SHALL have port host_d  in  8  host write data.
REQ-006 SHALL have port host_we  in  1  host write strobe, one write per cycle.
REQ-007 SHALL have port start  in  1  begin sequence; sampled only in IDLE.
REQ-008 SHALL have port abort  in  1  terminate sequence.
REQ-009 SHALL have port vact  in  1  active-frame indication from the vertical timing FSM.
REQ-010 SHALL have ports vfsm_a out 2, vfsm_d out 8, vfsm_we out 1  register write port to the vertical timing FSM.
REQ-011 SHALL have port vfsm_trigger  out  1  frame trigger to the vertical timing FSM.
REQ-012 SHALL have ports busy out 1, frame_done out 1, err out 1, frames_left out 8  status.

Function
REQ-013 Host map SHALL be: 0-3 shadow of vfsm regs 0-3; 4/5 gap lo/hi (16-bit idle cycles between frames); 6 frame count (0 = continuous); 7 timeout (cycles = reg7 << TO_SHIFT, 0 = disabled).
REQ-014 Writes to 0-3 SHALL be accepted at any time and take effect at the next LOAD; writes to 4-7 while busy SHALL be ignored.
REQ-015 States SHALL be IDLE, LOAD, TRIG, WAIT_ON, WAIT_OFF, GAP.
REQ-016 IDLE: on start=1, SHALL load frames_left from reg 6 and go to LOAD next cycle; busy=1 in all states except IDLE.
REQ-017 LOAD: SHALL issue 4 consecutive writes, vfsm_we=1, vfsm_a=0,1,2,3, vfsm_d=shadow[a], one per cycle, then go to TRIG.
REQ-018 TRIG: SHALL assert vfsm_trigger for exactly one cycle, then go to WAIT_ON.
REQ-019 WAIT_ON: on vact=1 SHALL go to WAIT_OFF; WAIT_OFF: on vact=0 SHALL pulse frame_done one cycle.
REQ-020 On frame end, with frame count nonzero, frames_left SHALL decrement; reaching 0 SHALL return to IDLE, else go to GAP.
REQ-021 Continuous mode (reg 6 = 0) SHALL keep frames_left at 0 and always go to GAP.
REQ-022 GAP SHALL wait exactly gap cycles (gap=0: zero cycles, straight to LOAD) then go to LOAD.
REQ-023 Timeout counter SHALL run in WAIT_ON and WAIT_OFF, restart on each state entry; expiry SHALL set err sticky and return to IDLE.
REQ-024 abort=1 in any non-IDLE state SHALL return to IDLE next cycle, dropping vfsm_we/vfsm_trigger immediately; abort takes priority over start, vact and timeout in the same cycle.
REQ-025 err SHALL clear only on reset or on the next accepted start.
REQ-026 Gap and timeout counters SHALL be 16 and 16+TO_SHIFT bits; no wrap permitted.

Reset
REQ-027 With rst=0 at a clock edge: state IDLE; all host registers 0; vfsm_we, vfsm_trigger, busy, frame_done, err 0; vfsm_a 0, vfsm_d 0, frames_left 0.
REQ-028 Reset mid-sequence SHALL abandon any partial LOAD without further vfsm writes.

Structure
REQ-029 State encoding, host address constants and register-map widths SHALL live in shared package tim_pkg.
REQ-030 Gap/timeout down-counter SHALL be one sub-module tim_dcnt (load, enable, zero flag), instantiated twice.

Verification
REQ-031 Regs 0-3 = 11,22,33,44, count=1, start -> writes a=0..3 with d=11,22,33,44 on 4 consecutive cycles, one-cycle trigger, frame_done after vact 1->0, busy drops.
REQ-032 count=3, gap=5, vact modelled -> 3 frame_done pulses, exactly 5 idle cycles between frame end and next LOAD, frames_left 2,1,0.
REQ-033 timeout reg=1 (TO_SHIFT 8), vact held 0 -> err=1 at 256 cycles after WAIT_ON entry, IDLE.
REQ-034 abort during LOAD after 2nd write -> no 3rd write, IDLE next cycle; abort and vact fall same cycle -> no frame_done.
REQ-035 Write reg 4 while busy -> gap unchanged; write reg 0 while busy -> new value on next LOAD.
REQ-036 rst=0 in WAIT_OFF -> all outputs at reset values next cycle.
